// File: rtl/nmu_port_pkg.sv
// nmu_port_pkg
// Shared constants and types for the L4 port CAM / egress rewrite blocks.
//   - Byte offsets of the L4 fields from the start of the Ethernet frame
//     (no IP options), the largest IP options length, the egress FSM state
//     type and a helper that maps a byte offset onto a 16-bit bus lane.
// No ports (package).
package nmu_port_pkg;

    localparam int SPORT_OFFSET     = 34;
    localparam int DPORT_OFFSET     = 36;
    localparam int PORT_SIZE        = 16;
    localparam int UDP_CSUM_OFFSET  = 40;
    localparam int LAST_BYTE        = 41;
    localparam int MAX_ADDED_OFFSET = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } egress_state_t;

    // Index of the 16-bit lane (within one bus beat) holding byte_offset.
    function automatic int lane_index(input int byte_offset, input int bus_bytes);
        return (byte_offset % bus_bytes) / (PORT_SIZE / 8);
    endfunction

endpackage

// File: rtl/port_egress_rewrite_skid.sv
// axis_skid_buffer
// Two-entry AXI-Stream register slice. The output is fully registered and
// in_ready is a registered signal, so neither path is combinational from
// the far side. Full throughput under continuous flow; the second entry
// absorbs the beat that arrives in the cycle the output stalls.
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   in_data/valid/ready    upstream side (in_ready is 0 during reset)
//   out_data/valid/ready   downstream side (out_valid is 0 during reset)
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= '0;
            skid_data  <= '0;
        end else if (!skid_valid) begin
            in_ready <= 1'b1;
            if (in_valid && in_ready) begin
                if (!out_valid || out_ready) begin
                    out_data  <= in_data;
                    out_valid <= 1'b1;
                end else begin
                    // Output stalled: park the beat and close the input.
                    skid_data  <= in_data;
                    skid_valid <= 1'b1;
                    in_ready   <= 1'b0;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end else if (out_ready) begin
            out_data   <= skid_data;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end
    end

endmodule

// File: rtl/port_egress_rewrite.sv
// port_egress_rewrite
// TX-side source-port enforcement. For TCP/UDP packets from a tid whose
// enforce bit is set, the L4 source port is overwritten with that tid's
// assigned port. The rewrite is muxed onto the beat entering a skid buffer,
// giving a 1-cycle registered stage with full throughput.
// Optional feature macro: PORT_EGRESS_UDP_CSUM_CLR_EN
//   defined   - on a rewritten UDP packet the UDP checksum is forced to 0
//   undefined - is_udp_in is ignored, checksum passes through
// Ports:
//   aclk, aresetn            clock, synchronous active-low reset
//   axis_in_*                input stream (tdata/tid/tdest/tkeep/tlast/tvalid, tready out)
//   axis_out_*               output stream (same fields, tready in)
//   has_ports_in             packet is TCP/UDP (first beat only)
//   is_udp_in                packet is UDP (first beat only)
//   added_offset_in          IP options length in bytes (first beat only)
//   ports                    per-tid source port, bus byte order
//   port_cam_must_match      per-tid enforce bit
//   rewrite_pulse            one pulse per rewritten packet, on the output handshake
//   rewrite_tid              tid of that rewrite
module port_egress_rewrite
    import nmu_port_pkg::*;
#(
    parameter int AXIS_BUS_WIDTH    = 64,
    parameter int AXIS_ID_WIDTH     = 4,
    parameter int AXIS_DEST_WIDTH   = 4,
    parameter int MAX_PACKET_LENGTH = 1522
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic [AXIS_BUS_WIDTH-1:0]            axis_in_tdata,
    input  logic [AXIS_ID_WIDTH-1:0]             axis_in_tid,
    input  logic [AXIS_DEST_WIDTH-1:0]           axis_in_tdest,
    input  logic [AXIS_BUS_WIDTH/8-1:0]          axis_in_tkeep,
    input  logic                                 axis_in_tlast,
    input  logic                                 axis_in_tvalid,
    output logic                                 axis_in_tready,
    output logic [AXIS_BUS_WIDTH-1:0]            axis_out_tdata,
    output logic [AXIS_ID_WIDTH-1:0]             axis_out_tid,
    output logic [AXIS_DEST_WIDTH-1:0]           axis_out_tdest,
    output logic [AXIS_BUS_WIDTH/8-1:0]          axis_out_tkeep,
    output logic                                 axis_out_tlast,
    output logic                                 axis_out_tvalid,
    input  logic                                 axis_out_tready,
    input  logic                                 has_ports_in,
    input  logic                                 is_udp_in,
    input  logic [6:0]                           added_offset_in,
    input  logic [2**AXIS_ID_WIDTH-1:0][15:0]    ports,
    input  logic [2**AXIS_ID_WIDTH-1:0]          port_cam_must_match,
    output logic                                 rewrite_pulse,
    output logic [AXIS_ID_WIDTH-1:0]             rewrite_tid
);

    localparam int BYTES     = AXIS_BUS_WIDTH / 8;
    localparam int LOG_BYTES = $clog2(BYTES);
    localparam int LANES     = AXIS_BUS_WIDTH / PORT_SIZE;
    localparam int CBITS     = $clog2(MAX_PACKET_LENGTH + 1);
    localparam int PAYLOAD_W = 1 + AXIS_ID_WIDTH + 1 + AXIS_DEST_WIDTH
                             + AXIS_ID_WIDTH + BYTES + AXIS_BUS_WIDTH;
    localparam logic [CBITS-1:0] CNT_MAX = '1;

    egress_state_t state, state_nxt;

    logic [CBITS-1:0]         beat_cnt;
    logic [AXIS_ID_WIDTH-1:0] tid_q;
    logic                     do_q;
    logic [6:0]               off_q;
    logic [15:0]              port_q;

    logic                     in_fire;
    logic                     first_beat;
    logic [AXIS_ID_WIDTH-1:0] cur_tid;
    logic                     cur_do;
    logic [6:0]               cur_off;
    logic [15:0]              cur_port;
    logic [CBITS-1:0]         sport_off;
    logic [CBITS-1:0]         sport_beat;
    logic                     sport_hit;
    int                       sport_lane;

    logic [AXIS_BUS_WIDTH-1:0] data_mod;
    logic                      rewrite_now;

    logic [PAYLOAD_W-1:0]     in_payload;
    logic [PAYLOAD_W-1:0]     out_payload;
    logic                     out_flag;
    logic [AXIS_ID_WIDTH-1:0] out_rew_tid;

    assign in_fire    = axis_in_tvalid & axis_in_tready;
    assign first_beat = (state == IDLE);

    // On the first beat the packet attributes come straight from the inputs;
    // afterwards only the copies latched on that beat are used, so mid-packet
    // changes on the sideband or the CAM tables have no effect.
    assign cur_tid  = first_beat ? axis_in_tid : tid_q;
    assign cur_do   = first_beat ? (has_ports_in & port_cam_must_match[axis_in_tid]) : do_q;
    assign cur_off  = first_beat ? added_offset_in : off_q;
    assign cur_port = first_beat ? ports[axis_in_tid] : port_q;

    assign sport_off  = CBITS'(SPORT_OFFSET) + CBITS'(cur_off);
    assign sport_beat = sport_off >> LOG_BYTES;
    assign sport_lane = lane_index(int'(sport_off), BYTES);
    // BODY excludes a second hit should the beat counter ever saturate.
    assign sport_hit  = (state != BODY) && (beat_cnt == sport_beat);

`ifdef PORT_EGRESS_UDP_CSUM_CLR_EN
    logic             udp_q;
    logic             cur_udp;
    logic [CBITS-1:0] csum_off;
    logic             csum_hit;
    int               csum_lane;

    assign cur_udp   = first_beat ? is_udp_in : udp_q;
    assign csum_off  = CBITS'(UDP_CSUM_OFFSET) + CBITS'(cur_off);
    assign csum_lane = lane_index(int'(csum_off), BYTES);
    assign csum_hit  = (beat_cnt == (csum_off >> LOG_BYTES));

    always_ff @(posedge aclk) begin
        if (!aresetn)
            udp_q <= 1'b0;
        else if (in_fire && first_beat)
            udp_q <= is_udp_in;
    end
`else
    logic unused_is_udp;
    assign unused_is_udp = is_udp_in;
`endif

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (in_fire) begin
            if (axis_in_tlast) begin
                state_nxt = IDLE;
            end else begin
                case (state)
                    IDLE:    state_nxt = sport_hit ? BODY : HDR;
                    HDR:     if (sport_hit) state_nxt = BODY;
                    default: state_nxt = state;
                endcase
            end
        end
    end

    // Output logic: lane rewrite on the beat entering the register slice
    always_comb begin
        data_mod    = axis_in_tdata;
        rewrite_now = 1'b0;
        if (cur_do && sport_hit) begin
            rewrite_now = 1'b1;
            for (int k = 0; k < LANES; k++) begin
                if (k == sport_lane)
                    data_mod[k*PORT_SIZE +: PORT_SIZE] = cur_port;
            end
        end
`ifdef PORT_EGRESS_UDP_CSUM_CLR_EN
        // The checksum lane always follows the port lane, so a hit here
        // implies the port rewrite already happened in this packet.
        if (cur_do && cur_udp && csum_hit) begin
            for (int k = 0; k < LANES; k++) begin
                if (k == csum_lane)
                    data_mod[k*PORT_SIZE +: PORT_SIZE] = '0;
            end
        end
`endif
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            beat_cnt <= '0;
            tid_q    <= '0;
            do_q     <= 1'b0;
            off_q    <= '0;
            port_q   <= '0;
        end else if (in_fire) begin
            if (axis_in_tlast)
                beat_cnt <= '0;
            else if (beat_cnt != CNT_MAX)
                beat_cnt <= beat_cnt + CBITS'(1);
            if (first_beat) begin
                tid_q  <= axis_in_tid;
                do_q   <= has_ports_in & port_cam_must_match[axis_in_tid];
                off_q  <= added_offset_in;
                port_q <= ports[axis_in_tid];
            end
        end
    end

    assign in_payload = {rewrite_now, cur_tid, axis_in_tlast, axis_in_tdest,
                         axis_in_tid, axis_in_tkeep, data_mod};

    axis_skid_buffer #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_data   (in_payload),
        .in_valid  (axis_in_tvalid),
        .in_ready  (axis_in_tready),
        .out_data  (out_payload),
        .out_valid (axis_out_tvalid),
        .out_ready (axis_out_tready)
    );

    assign {out_flag, out_rew_tid, axis_out_tlast, axis_out_tdest,
            axis_out_tid, axis_out_tkeep, axis_out_tdata} = out_payload;

    assign rewrite_pulse = out_flag & axis_out_tvalid & axis_out_tready;
    assign rewrite_tid   = out_rew_tid;

endmodule

// File: tb/tb_port_egress_rewrite.sv
`timescale 1ns/1ps
module tb_port_egress_rewrite;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [63:0] axis_in_tdata;
    logic [3:0]  axis_in_tid;
    logic [3:0]  axis_in_tdest;
    logic [7:0]  axis_in_tkeep;
    logic        axis_in_tlast;
    logic        axis_in_tvalid;
    logic        axis_in_tready;
    logic [63:0] axis_out_tdata;
    logic [3:0]  axis_out_tid;
    logic [3:0]  axis_out_tdest;
    logic [7:0]  axis_out_tkeep;
    logic        axis_out_tlast;
    logic        axis_out_tvalid;
    logic        axis_out_tready;
    logic        has_ports_in;
    logic        is_udp_in;
    logic [6:0]  added_offset_in;
    logic [15:0][15:0] ports;
    logic [15:0] port_cam_must_match;
    logic        rewrite_pulse;
    logic [3:0]  rewrite_tid;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic [3:0]  id;
        logic [3:0]  de;
        logic        l;
        logic        p;
        logic [3:0]  rt;
        int          cyc;
    } obeat_t;

    obeat_t oq[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int kz = -1;
    int rdy_mode = 0;
    int first_acc_cyc = 0;
    int last_out_cyc = 0;

    port_egress_rewrite dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .axis_in_tdata       (axis_in_tdata),
        .axis_in_tid         (axis_in_tid),
        .axis_in_tdest       (axis_in_tdest),
        .axis_in_tkeep       (axis_in_tkeep),
        .axis_in_tlast       (axis_in_tlast),
        .axis_in_tvalid      (axis_in_tvalid),
        .axis_in_tready      (axis_in_tready),
        .axis_out_tdata      (axis_out_tdata),
        .axis_out_tid        (axis_out_tid),
        .axis_out_tdest      (axis_out_tdest),
        .axis_out_tkeep      (axis_out_tkeep),
        .axis_out_tlast      (axis_out_tlast),
        .axis_out_tvalid     (axis_out_tvalid),
        .axis_out_tready     (axis_out_tready),
        .has_ports_in        (has_ports_in),
        .is_udp_in           (is_udp_in),
        .added_offset_in     (added_offset_in),
        .ports               (ports),
        .port_cam_must_match (port_cam_must_match),
        .rewrite_pulse       (rewrite_pulse),
        .rewrite_tid         (rewrite_tid)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Input pattern: every byte distinct per beat, no lane equal to a test port or zero.
    function automatic logic [63:0] pat(input logic [3:0] id, input int b);
        logic [7:0] bb;
        bb = 8'(b);
        return 64'hF0E1_D2C3_B4A5_9687 ^ {8{bb}} ^ {id, 60'h0};
    endfunction

    // Downstream ready: 0 = always ready, 1 = random 50%.
    initial begin
        axis_out_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            axis_out_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Output monitor: log handshakes, and check stalled beats are held.
    logic        prev_stall = 1'b0;
    logic [63:0] prev_d;
    logic [4:0]  prev_meta;
    always @(negedge aclk) begin
        if (aresetn && prev_stall) begin
            chk("hold_valid", 64'(axis_out_tvalid), 64'd1);
            chk("hold_beat", {axis_out_tdata ^ prev_d}, 64'd0);
            chk("hold_meta", 64'({axis_out_tlast, axis_out_tid}), 64'(prev_meta));
        end
        prev_stall = aresetn && axis_out_tvalid && !axis_out_tready;
        prev_d     = axis_out_tdata;
        prev_meta  = {axis_out_tlast, axis_out_tid};
        if (axis_out_tvalid && axis_out_tready)
            oq.push_back('{d: axis_out_tdata, k: axis_out_tkeep, id: axis_out_tid,
                           de: axis_out_tdest, l: axis_out_tlast, p: rewrite_pulse,
                           rt: rewrite_tid, cyc: cyc});
    end

    // Sends beats 0..nsend-1 of an nb-beat packet. Non-first beats carry
    // contradicting sideband values; ports/must_match for the tid are
    // replaced right after the first beat is accepted.
    task automatic send_pkt(input logic [3:0] id, input int nb, input int nsend,
                            input logic hp, input logic udp, input logic [6:0] off,
                            input logic [15:0] mid_port, input logic mid_mm);
        for (int b = 0; b < nsend; b++) begin
            int guard;
            axis_in_tvalid  = 1'b1;
            axis_in_tdata   = pat(id, b);
            axis_in_tkeep   = (b == kz) ? 8'h00 : 8'hFF;
            axis_in_tid     = id;
            axis_in_tdest   = ~id;
            axis_in_tlast   = (b == nb - 1);
            has_ports_in    = (b == 0) ? hp : ~hp;
            is_udp_in       = (b == 0) ? udp : ~udp;
            added_offset_in = (b == 0) ? off : 7'd62;
            guard = 0;
            while (!axis_in_tready && guard < 500) begin
                @(posedge aclk);
                #1;
                guard++;
            end
            if (guard >= 500) begin
                checks++;
                failures++;
                $error("FAIL in_ready_timeout observed=%0d cycles expected<500", guard);
            end
            @(posedge aclk);
            #1;
            if (b == 0) begin
                first_acc_cyc = cyc;
                ports[id] = mid_port;
                port_cam_must_match[id] = mid_mm;
            end
        end
        axis_in_tvalid = 1'b0;
    endtask

    // Expected packet: input pattern with lane [rlsb+:16] of beat rb set to rv
    // (the rewrite, which also carries the pulse) and lane [clsb+:16] of beat
    // cb set to cv. rb/cb = -1 means no modification.
    task automatic check_pkt(input string tag, input logic [3:0] id, input int nb,
                             input int rb, input int rlsb, input logic [15:0] rv,
                             input int cb, input int clsb, input logic [15:0] cv);
        int guard = 0;
        obeat_t ob;
        logic [63:0] e;
        while (oq.size() < nb && guard < 1000) begin
            @(posedge aclk);
            #1;
            guard++;
        end
        if (oq.size() < nb) begin
            checks++;
            failures++;
            $error("FAIL %s_timeout observed=%0d beats expected=%0d", tag, oq.size(), nb);
        end else begin
            for (int b = 0; b < nb; b++) begin
                ob = oq.pop_front();
                e = pat(id, b);
                if (b == rb) e[rlsb +: 16] = rv;
                if (b == cb) e[clsb +: 16] = cv;
                if (b == 0) last_out_cyc = ob.cyc;
                chk({tag, "_data"}, ob.d, e);
                chk({tag, "_meta"}, 64'({ob.l, ob.id, ob.de, ob.k}),
                    64'({(b == nb - 1), id, ~id, ((b == kz) ? 8'h00 : 8'hFF)}));
                chk({tag, "_pulse"}, 64'(ob.p), 64'(b == rb));
                if (ob.p) chk({tag, "_rtid"}, 64'(ob.rt), 64'(id));
            end
        end
    endtask

    initial begin
        aresetn = 1'b0;
        axis_in_tdata = '0;
        axis_in_tid = '0;
        axis_in_tdest = '0;
        axis_in_tkeep = '0;
        axis_in_tlast = 1'b0;
        axis_in_tvalid = 1'b0;
        has_ports_in = 1'b0;
        is_udp_in = 1'b0;
        added_offset_in = '0;
        ports = '0;
        ports[2] = 16'h1234;
        port_cam_must_match = '0;
        port_cam_must_match[2] = 1'b1;

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_in_ready", 64'(axis_in_tready), 64'd0);
        chk("rst_out_valid", 64'(axis_out_tvalid), 64'd0);
        chk("rst_pulse", 64'(rewrite_pulse), 64'd0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("post_rst_in_ready", 64'(axis_in_tready), 64'd1);

        // Offset 0: byte 34 -> beat 4 bits [31:16]; port changed mid-packet is ignored.
        send_pkt(4'd2, 8, 8, 1'b1, 1'b0, 7'd0, 16'hBEEF, 1'b1);
        check_pkt("off0", 4'd2, 8, 4, 16, 16'h1234, -1, 0, 16'h0);
        chk("latency", 64'(last_out_cyc), 64'(first_acc_cyc));
        ports[2] = 16'h1234;

        // Offset 4: byte 38 -> beat 4 bits [63:48].
        send_pkt(4'd2, 8, 8, 1'b1, 1'b0, 7'd4, 16'h1234, 1'b1);
        check_pkt("off4", 4'd2, 8, 4, 48, 16'h1234, -1, 0, 16'h0);

        // Offset 8: byte 42 -> beat 5 bits [31:16].
        send_pkt(4'd2, 8, 8, 1'b1, 1'b0, 7'd8, 16'h1234, 1'b1);
        check_pkt("off8", 4'd2, 8, 5, 16, 16'h1234, -1, 0, 16'h0);

        // Offset 64: byte 98 -> beat 12 bits [31:16].
        send_pkt(4'd2, 14, 14, 1'b1, 1'b0, 7'd64, 16'h1234, 1'b1);
        check_pkt("off64", 4'd2, 14, 12, 16, 16'h1234, -1, 0, 16'h0);

        // Enforce bit clear at the first beat (set mid-packet): untouched.
        port_cam_must_match[2] = 1'b0;
        send_pkt(4'd2, 8, 8, 1'b1, 1'b0, 7'd0, 16'h1234, 1'b1);
        check_pkt("no_enforce", 4'd2, 8, -1, 0, 16'h0, -1, 0, 16'h0);

        // Not TCP/UDP: untouched.
        send_pkt(4'd2, 8, 8, 1'b0, 1'b0, 7'd0, 16'h1234, 1'b1);
        check_pkt("no_ports", 4'd2, 8, -1, 0, 16'h0, -1, 0, 16'h0);

        // Short packets end before the port beat; the next packet still rewrites.
        send_pkt(4'd2, 3, 3, 1'b1, 1'b0, 7'd0, 16'h1234, 1'b1);
        send_pkt(4'd2, 1, 1, 1'b1, 1'b0, 7'd0, 16'h1234, 1'b1);
        send_pkt(4'd2, 8, 8, 1'b1, 1'b0, 7'd0, 16'h1234, 1'b1);
        check_pkt("short3", 4'd2, 3, -1, 0, 16'h0, -1, 0, 16'h0);
        check_pkt("short1", 4'd2, 1, -1, 0, 16'h0, -1, 0, 16'h0);
        check_pkt("after_short", 4'd2, 8, 4, 16, 16'h1234, -1, 0, 16'h0);

        // Port lane with tkeep=0 is still rewritten and pulses.
        kz = 4;
        send_pkt(4'd2, 8, 8, 1'b1, 1'b0, 7'd0, 16'h1234, 1'b1);
        check_pkt("keep0", 4'd2, 8, 4, 16, 16'h1234, -1, 0, 16'h0);
        kz = -1;

        // UDP checksum lane: byte 40 -> beat 5 bits [15:0].
`ifdef PORT_EGRESS_UDP_CSUM_CLR_EN
        send_pkt(4'd2, 8, 8, 1'b1, 1'b1, 7'd0, 16'h1234, 1'b1);
        check_pkt("udp_csum_clr", 4'd2, 8, 4, 16, 16'h1234, 5, 0, 16'h0000);
`else
        send_pkt(4'd2, 8, 8, 1'b1, 1'b1, 7'd0, 16'h1234, 1'b1);
        check_pkt("udp_csum_keep", 4'd2, 8, 4, 16, 16'h1234, -1, 0, 16'h0);
`endif
        send_pkt(4'd2, 8, 8, 1'b1, 1'b0, 7'd0, 16'h1234, 1'b1);
        check_pkt("tcp_csum_keep", 4'd2, 8, 4, 16, 16'h1234, -1, 0, 16'h0);

        // Random downstream ready, back-to-back packets on tids 1/2/3.
        ports[1] = 16'h1111;
        ports[3] = 16'h3333;
        port_cam_must_match[1] = 1'b1;
        port_cam_must_match[3] = 1'b1;
        rdy_mode = 1;
        send_pkt(4'd1, 6, 6, 1'b1, 1'b0, 7'd0, 16'h1111, 1'b1);
        send_pkt(4'd2, 6, 6, 1'b1, 1'b0, 7'd0, 16'h1234, 1'b1);
        send_pkt(4'd3, 6, 6, 1'b1, 1'b0, 7'd0, 16'h3333, 1'b1);
        check_pkt("rnd_t1", 4'd1, 6, 4, 16, 16'h1111, -1, 0, 16'h0);
        check_pkt("rnd_t2", 4'd2, 6, 4, 16, 16'h1234, -1, 0, 16'h0);
        check_pkt("rnd_t3", 4'd3, 6, 4, 16, 16'h3333, -1, 0, 16'h0);
        rdy_mode = 0;
        repeat (2) @(posedge aclk);
        #1;
        chk("rnd_no_extra", 64'(oq.size()), 64'd0);

        // Reset for one cycle while beat 2 is offered.
        send_pkt(4'd2, 8, 2, 1'b1, 1'b0, 7'd0, 16'h1234, 1'b1);
        axis_in_tvalid = 1'b1;
        axis_in_tdata  = pat(4'd2, 2);
        axis_in_tlast  = 1'b0;
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        axis_in_tvalid = 1'b0;
        chk("mid_rst_out_valid", 64'(axis_out_tvalid), 64'd0);
        chk("mid_rst_in_ready", 64'(axis_in_tready), 64'd0);
        @(posedge aclk);
        #1;
        oq.delete();
        send_pkt(4'd2, 8, 8, 1'b1, 1'b0, 7'd0, 16'h1234, 1'b1);
        check_pkt("after_rst", 4'd2, 8, 4, 16, 16'h1234, -1, 0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
